// File: rtl/alu_pkg.sv
// Shared definitions for the ALU input sequencer.
// Holds the opcode width and the operand-loading state encoding.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Active-low push button conditioner: 2-flop sync, optional debounce
// (INPUT_DEBOUNCE_EN), and a one-cycle press pulse on each debounced fall.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic       s1;
    logic       s2;
    logic       level;
    logic       prev;
    logic       armed;
    logic [1:0] live;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    // Arm only after a real released sample, so a held press survives reset silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            live  <= 2'b00;
            armed <= 1'b0;
        end else begin
            live <= {live[0], 1'b1};
            if (live[1] && s2)
                armed <= 1'b1;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Accept a new level only after it differs for DB_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (s2 != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_db;
    assign unused_db = (DB_CYCLES != 0);
    assign level     = s2;
`endif

    // Remember last level to find the 1->0 edge.
    always_ff @(posedge clk) begin
        if (rst)
            prev <= 1'b1;
        else
            prev <= level;
    end

    assign press = armed & prev & ~level;

endmodule

// File: rtl/alu_input_sequencer.sv
// Latches operand A, operand B and opcode from switches on button presses.
// Button debounce is compiled in when INPUT_DEBOUNCE_EN is defined.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int N         = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        data_sw,
    input  logic [ALU_OP_W-1:0] op_sw,
    input  logic                btn_load_n,
    input  logic                btn_clr_n,
    output logic [N-1:0]        a_o,
    output logic [N-1:0]        b_o,
    output logic [ALU_OP_W-1:0] op_o,
    output logic                valid_o,
    output logic [1:0]          state_o
);

    logic       load_ev;
    logic       clr_ev;
    seq_state_e state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_load_n),
        .press (load_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_clr_n),
        .press (clr_ev)
    );

    // Step through A, B, opcode on each load; clear overrides a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst || clr_ev) begin
            state <= LOAD_A;
            a_o   <= '0;
            b_o   <= '0;
            op_o  <= '0;
        end else if (load_ev) begin
            unique case (state)
                LOAD_A: begin
                    a_o   <= data_sw;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    b_o   <= data_sw;
                    state <= LOAD_OP;
                end
                LOAD_OP: begin
                    op_o  <= op_sw;
                    state <= READY;
                end
                READY: begin
                    a_o   <= data_sw;
                    state <= LOAD_B;
                end
            endcase
        end
    end

    assign state_o = state;
    assign valid_o = (state == READY);

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer (N=4, DB_CYCLES=4).
// Latency expectations follow INPUT_DEBOUNCE_EN.
module tb_alu_input_sequencer;

    localparam int N  = 4;
    localparam int DB = 4;
`ifdef INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + DB + 1;
`else
    localparam int LAT = 3;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] data_sw;
    logic [2:0]   op_sw;
    logic         btn_load_n;
    logic         btn_clr_n;
    logic [N-1:0] a_o;
    logic [N-1:0] b_o;
    logic [2:0]   op_o;
    logic         valid_o;
    logic [1:0]   state_o;

    int errs   = 0;
    int checks = 0;

    alu_input_sequencer #(.N(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_sw    (data_sw),
        .op_sw      (op_sw),
        .btn_load_n (btn_load_n),
        .btn_clr_n  (btn_clr_n),
        .a_o        (a_o),
        .b_o        (b_o),
        .op_o       (op_o),
        .valid_o    (valid_o),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] o;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [2:0] eo;
        logic       ev;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ea,
                           input logic [3:0] eb, input logic [2:0] eo,
                           input logic ev, input logic [1:0] es);
        chk({tag, "_a"}, 32'(a_o), 32'(ea));
        chk({tag, "_b"}, 32'(b_o), 32'(eb));
        chk({tag, "_op"}, 32'(op_o), 32'(eo));
        chk({tag, "_valid"}, 32'(valid_o), 32'(ev));
        chk({tag, "_state"}, 32'(state_o), 32'(es));
    endtask

    // Hold load, then scramble switches before release: no further effect.
    task automatic press_load(input logic [3:0] d, input logic [2:0] o);
        data_sw    = d;
        op_sw      = o;
        btn_load_n = 1'b0;
        tick(LAT + 2);
        data_sw = ~d;
        op_sw   = ~o;
        tick(2);
        btn_load_n = 1'b1;
        tick(LAT + 4);
    endtask

    task automatic press_clr();
        btn_clr_n = 1'b0;
        tick(LAT + 2);
        btn_clr_n = 1'b1;
        tick(LAT + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'b1010, 3'b000, 4'b1010, 4'b0000, 3'b000, 1'b0, 2'd1};
        vecs[1] = '{4'b0011, 3'b000, 4'b1010, 4'b0011, 3'b000, 1'b0, 2'd2};
        vecs[2] = '{4'b0111, 3'b101, 4'b1010, 4'b0011, 3'b101, 1'b1, 2'd3};
        vecs[3] = '{4'b1111, 3'b010, 4'b1111, 4'b0011, 3'b101, 1'b0, 2'd1};
        vecs[4] = '{4'b0001, 3'b000, 4'b1111, 4'b0001, 3'b101, 1'b0, 2'd2};
        vecs[5] = '{4'b1000, 3'b110, 4'b1111, 4'b0001, 3'b110, 1'b1, 2'd3};

        rst        = 1'b1;
        data_sw    = '0;
        op_sw      = '0;
        btn_load_n = 1'b1;
        btn_clr_n  = 1'b1;
        tick(2);
        chk_all("reset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
        rst = 1'b0;
        tick(4);

        // Latency from a clean press to the A latch edge.
        data_sw    = 4'b0110;
        btn_load_n = 1'b0;
        tick(1);
`ifndef INPUT_DEBOUNCE_EN
        btn_load_n = 1'b1;
`endif
        tick(LAT - 2);
        chk("lat_before", 32'(state_o), 32'd0);
        tick(1);
        chk("lat_state", 32'(state_o), 32'd1);
        chk("lat_a", 32'(a_o), 32'(4'b0110));
        btn_load_n = 1'b1;
        tick(LAT + 4);

        press_clr();
        chk_all("clr_b", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);

        for (int i = 0; i < 6; i++) begin
            press_load(vecs[i].d, vecs[i].o);
            chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                    vecs[i].eo, vecs[i].ev, vecs[i].es);
        end

        press_clr();
        chk_all("clr_rdy", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);

`ifdef INPUT_DEBOUNCE_EN
        begin
            int moved = 0;
            data_sw = 4'b1001;
            for (int i = 0; i < 20; i++) begin
                btn_load_n = ((i / 2) % 2) != 0;
                tick(1);
                if (state_o != 2'd0)
                    moved++;
            end
            chk("bounce_quiet", 32'(moved), 32'd0);
            btn_load_n = 1'b0;
            tick(LAT - 1);
            chk("bounce_before", 32'(state_o), 32'd0);
            tick(1);
            chk("bounce_state", 32'(state_o), 32'd1);
            chk("bounce_a", 32'(a_o), 32'(4'b1001));
        end
`else
        data_sw    = 4'b1001;
        btn_load_n = 1'b0;
        tick(LAT + 7);
        chk("hold_state", 32'(state_o), 32'd1);
        chk("hold_a", 32'(a_o), 32'(4'b1001));
`endif
        btn_load_n = 1'b1;
        tick(LAT + 4);
        chk("release_state", 32'(state_o), 32'd1);

        // Load and clear fall together while in LOAD_B.
        data_sw    = 4'b1111;
        btn_load_n = 1'b0;
        btn_clr_n  = 1'b0;
        tick(LAT + 2);
        chk_all("simul", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
        btn_load_n = 1'b1;
        btn_clr_n  = 1'b1;
        tick(LAT + 4);

        // Reset two cycles into a press; the held press must stay silent.
        press_load(4'b0101, 3'd0);
        chk("pre_rst_a", 32'(a_o), 32'(4'b0101));
        data_sw    = 4'b1100;
        btn_load_n = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(LAT + 8);
        chk("rst_hold_state", 32'(state_o), 32'd0);
        chk("rst_hold_a", 32'(a_o), 32'd0);
        btn_load_n = 1'b1;
        tick(LAT + 4);
        chk("rst_rel_state", 32'(state_o), 32'd0);
        press_load(4'b1100, 3'd0);
        chk("rst_repress_state", 32'(state_o), 32'd1);
        chk("rst_repress_a", 32'(a_o), 32'(4'b1100));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits.
REQ-002 SHALL have parameter DB_CYCLES, default 500000: cycles a synchronized button level must be stable before it is accepted.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port data_sw, input, N: operand switches, asynchronous.
REQ-006 SHALL have port op_sw, input, 3: operation-select switches, asynchronous.
REQ-007 SHALL have port btn_load_n, input, 1: load push button, active-low (0 = pressed), asynchronous.
REQ-008 SHALL have port btn_clr_n, input, 1: clear push button, active-low, asynchronous.
REQ-009 SHALL have port a_o, output, N: latched operand A, fed to the ALU input a.
REQ-010 SHALL have port b_o, output, N: latched operand B, fed to the ALU input b.
REQ-011 SHALL have port op_o, output, 3: latched operation code, fed to the ALU input op.
REQ-012 SHALL have port valid_o, output, 1: high while a_o, b_o and op_o form a complete set.
REQ-013 SHALL have port state_o, output, 2: current FSM state, for status LEDs.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its stable level only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release (0->1) SHALL generate no event; holding the button SHALL generate exactly one event.
REQ-016 FSM states SHALL be LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3, reported on state_o.
REQ-017 On a load event: LOAD_A SHALL latch data_sw into a_o and go to LOAD_B; LOAD_B SHALL latch data_sw into b_o and go to LOAD_OP; LOAD_OP SHALL latch op_sw into op_o and go to READY.
REQ-018 In READY, a load event SHALL latch data_sw into a_o, leave b_o and op_o unchanged, and go to LOAD_B.
REQ-019 valid_o SHALL be high exactly in READY; it SHALL rise on the cycle after the op_o latch edge and fall on the cycle after the edge that leaves READY.
REQ-020 Outputs SHALL change only on latch edges; switch changes between events SHALL have no effect.
REQ-021 A clear event SHALL zero a_o, b_o and op_o, drop valid_o and go to LOAD_A from any state.
REQ-022 If clear and load events occur in the same cycle, clear SHALL win and the load SHALL be discarded.
REQ-023 Latency from a clean button press to the latch edge SHALL be 2 + DB_CYCLES + 1 cycles.

Reset
REQ-024 While rst=1 at a clock edge: a_o=0, b_o=0, op_o=0, valid_o=0, state_o=LOAD_A; synchronizers and debounced levels SHALL be 1 (released); debounce counters SHALL be 0.
REQ-025 A press held across reset release SHALL NOT produce an event until it has been released and pressed again.

Configuration
REQ-026 With macro INPUT_DEBOUNCE_EN defined, the debouncers SHALL be compiled in as described in REQ-014.
REQ-027 With INPUT_DEBOUNCE_EN undefined, the debouncers SHALL be bypassed: the synchronized level is the debounced level, and latency is 3 cycles.

Structure
REQ-028 Shared package alu_pkg SHALL hold ALU_OP_W=3 and the state enum type (LOAD_A..READY).
REQ-029 Debouncing and edge detection SHALL be a sub-module btn_debounce, instantiated once per button.

Verification (N=4, DB_CYCLES=4)
REQ-030 Clean sequence: press load with data_sw=1010, then 0011, then op_sw=101 -> a_o=1010, b_o=0011, op_o=101, valid_o=1, state_o=3.
REQ-031 Bounce: btn_load_n toggles 0/1 every 2 cycles for 20 cycles, then is held at 0 -> exactly one latch, occurring 7 cycles after the final fall.
REQ-032 READY reload: from the REQ-030 end state, press load with data_sw=1111 -> a_o=1111, b_o=0011, op_o=101, valid_o=0, state_o=1.
REQ-033 Simultaneous press: load and clear fall in the same cycle while in LOAD_B -> all outputs are 0 and state_o=0.
REQ-034 Reset mid-debounce: rst=1 for 1 cycle, 2 cycles into a press -> no latch; the same press still held afterwards produces no event.
REQ-035 Without INPUT_DEBOUNCE_EN: a single 1-cycle-wide low pulse on btn_load_n latches A 3 cycles later.
